// File: rtl/quad_encoder_reader.sv
// quad_encoder_reader
//   Quadrature encoder interface with an Avalon-MM register slave. Counts x4-decoded steps
//   into a signed 32-bit POSITION, latches POSITION on the index pulse, flags illegal
//   double transitions and measures net counts per programmable window (VELOCITY).
//
//   Optional build macro: QUAD_FILTER_EN adds a per-channel stability filter on A and B
//   whose length is set by FILTER_LEN. Without it, address 4 reads 0 and ignores writes.
//
// Ports
//   csi_MCLK_clk         system clock, rising edge
//   rsi_MRST_reset       asynchronous active-high reset
//   avs_ctrl_address     word register select (3 bits)
//   avs_ctrl_write/read  Avalon-MM strobes, write wins if both asserted
//   avs_ctrl_writedata   write data, byte lanes gated by avs_ctrl_byteenable
//   avs_ctrl_readdata    registered read data
//   avs_ctrl_waitrequest always 0
//   enc_a, enc_b, enc_z  asynchronous encoder channels and index pulse
//
// Register map
//   0 POSITION RW | 1 CONTROL RW {INDEX_CLR_EN, INVERT, ENABLE} | 2 STATUS {IDX, ERR, DIR}
//   3 INDEX_POS RO | 4 FILTER_LEN RW [7:0] | 5 WINDOW RW | 6 VELOCITY RO | 7 reads 0
module quad_encoder_reader (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,
  input  logic [2:0]  avs_ctrl_address,
  input  logic        avs_ctrl_write,
  input  logic        avs_ctrl_read,
  input  logic [31:0] avs_ctrl_writedata,
  input  logic [3:0]  avs_ctrl_byteenable,
  output logic [31:0] avs_ctrl_readdata,
  output logic        avs_ctrl_waitrequest,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        enc_z
);

  localparam logic [2:0] AddrPos    = 3'd0;
  localparam logic [2:0] AddrCtrl   = 3'd1;
  localparam logic [2:0] AddrStatus = 3'd2;
  localparam logic [2:0] AddrIdxPos = 3'd3;
  localparam logic [2:0] AddrFlen   = 3'd4;
  localparam logic [2:0] AddrWindow = 3'd5;
  localparam logic [2:0] AddrVel    = 3'd6;

  function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                          input logic [31:0] wdata,
                                          input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  // Synchronizers: bit2 = z, bit1 = a, bit0 = b
  logic [2:0]  r_sync_meta, r_sync;
  logic [1:0]  r_vld_pipe;   // marks when r_sync holds a real sample after reset
  logic        r_prev_vld;
  logic [1:0]  r_prev_ab;
  logic        r_z_prev;

  logic [31:0] r_pos, r_idx_pos, r_window, r_vel, r_win_cnt, r_net;
  logic [2:0]  r_ctrl;
  logic        r_dir, r_err, r_idx;

  logic [1:0]  w_ab;
  logic [1:0]  w_chg;
  logic        w_step, w_dbl, w_up, w_cnt, w_z_rise;
  logic [31:0] w_delta, w_pos_cnt, w_rdata;
  logic        w_wr_pos, w_wr_ctrl, w_wr_status, w_wr_win;

  assign avs_ctrl_waitrequest = 1'b0;

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_sync_meta <= '0;
      r_sync      <= '0;
      r_vld_pipe  <= '0;
    end else begin
      r_sync_meta <= {enc_z, enc_a, enc_b};
      r_sync      <= r_sync_meta;
      r_vld_pipe  <= {r_vld_pipe[0], 1'b1};
    end
  end

`ifdef QUAD_FILTER_EN
  logic [7:0] r_flen;
  logic [1:0] r_filt;
  logic [7:0] r_fcnt [2];
  logic [1:0] w_acc;

  // A channel change is accepted once it has differed for FILTER_LEN+1 cycles; with
  // FILTER_LEN=0 the new level passes straight through in its first cycle.
  always_comb begin
    w_acc = '0;
    w_ab  = r_filt;
    for (int i = 0; i < 2; i++) begin
      w_acc[i] = (r_sync[i] != r_filt[i]) && (r_fcnt[i] >= r_flen);
      if (w_acc[i]) w_ab[i] = r_sync[i];
    end
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_filt    <= '0;
      r_fcnt[0] <= '0;
      r_fcnt[1] <= '0;
    end else if (!r_prev_vld) begin
      r_filt    <= r_sync[1:0];
      r_fcnt[0] <= '0;
      r_fcnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync[i] == r_filt[i] || w_acc[i]) begin
          r_fcnt[i] <= '0;
          if (w_acc[i]) r_filt[i] <= r_sync[i];
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_flen <= '0;
    end else if (avs_ctrl_write && avs_ctrl_address == AddrFlen && avs_ctrl_byteenable[0]) begin
      r_flen <= avs_ctrl_writedata[7:0];
    end
  end
`else
  assign w_ab = r_sync[1:0];
`endif

  // Decoder: a single-bit change is a step; forward when prev.a differs from cur.b
  always_comb begin
    w_chg     = w_ab ^ r_prev_ab;
    w_step    = r_prev_vld && (w_chg == 2'b01 || w_chg == 2'b10);
    w_dbl     = r_prev_vld && (w_chg == 2'b11);
    w_up      = (r_prev_ab[1] ^ w_ab[0]) ^ r_ctrl[1];
    w_cnt     = w_step && r_ctrl[0];
    w_delta   = w_cnt ? (w_up ? 32'd1 : 32'hFFFF_FFFF) : 32'd0;
    w_pos_cnt = r_pos + w_delta;
    w_z_rise  = r_prev_vld && r_sync[2] && !r_z_prev;
  end

  always_comb begin
    w_wr_pos    = avs_ctrl_write && (avs_ctrl_address == AddrPos);
    w_wr_ctrl   = avs_ctrl_write && (avs_ctrl_address == AddrCtrl);
    w_wr_status = avs_ctrl_write && (avs_ctrl_address == AddrStatus) && avs_ctrl_byteenable[0];
    w_wr_win    = avs_ctrl_write && (avs_ctrl_address == AddrWindow);
  end

  // Previous state keeps tracking with ENABLE=0; the first valid sample seeds it silently
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_prev_ab  <= '0;
      r_prev_vld <= 1'b0;
      r_z_prev   <= 1'b0;
    end else if (r_vld_pipe[1]) begin
      r_prev_ab  <= r_prev_vld ? w_ab : r_sync[1:0];
      r_prev_vld <= 1'b1;
      r_z_prev   <= r_sync[2];
    end
  end

  // Position priority: host write, then index clear, then count
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_pos     <= '0;
      r_idx_pos <= '0;
      r_ctrl    <= '0;
    end else begin
      if (w_wr_pos)                   r_pos <= f_merge(r_pos, avs_ctrl_writedata,
                                                       avs_ctrl_byteenable);
      else if (w_z_rise && r_ctrl[2]) r_pos <= '0;
      else                            r_pos <= w_pos_cnt;
      if (w_z_rise) r_idx_pos <= w_pos_cnt;
      if (w_wr_ctrl && avs_ctrl_byteenable[0]) r_ctrl <= avs_ctrl_writedata[2:0];
    end
  end

  // Sticky flags: a set event in the same cycle beats a W1C clear
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_dir <= 1'b0;
      r_err <= 1'b0;
      r_idx <= 1'b0;
    end else begin
      if (w_cnt) r_dir <= w_up;
      if (w_dbl && r_ctrl[0])                         r_err <= 1'b1;
      else if (w_wr_status && avs_ctrl_writedata[1]) r_err <= 1'b0;
      if (w_z_rise)                                   r_idx <= 1'b1;
      else if (w_wr_status && avs_ctrl_writedata[2]) r_idx <= 1'b0;
    end
  end

  // Velocity window: the count of the closing cycle belongs to the window it closes
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      r_window  <= '0;
      r_win_cnt <= '0;
      r_net     <= '0;
      r_vel     <= '0;
    end else if (w_wr_win) begin
      r_window  <= f_merge(r_window, avs_ctrl_writedata, avs_ctrl_byteenable);
      r_win_cnt <= '0;
      r_net     <= '0;
    end else if (r_window == 32'd0) begin
      r_win_cnt <= '0;
      r_net     <= '0;
      r_vel     <= '0;
    end else if (r_win_cnt == r_window - 32'd1) begin
      r_vel     <= r_net + w_delta;
      r_win_cnt <= '0;
      r_net     <= '0;
    end else begin
      r_win_cnt <= r_win_cnt + 32'd1;
      r_net     <= r_net + w_delta;
    end
  end

  always_comb begin
    w_rdata = '0;
    unique case (avs_ctrl_address)
      AddrPos:    w_rdata = r_pos;
      AddrCtrl:   w_rdata = {29'd0, r_ctrl};
      AddrStatus: w_rdata = {29'd0, r_idx, r_err, r_dir};
      AddrIdxPos: w_rdata = r_idx_pos;
`ifdef QUAD_FILTER_EN
      AddrFlen:   w_rdata = {24'd0, r_flen};
`else
      AddrFlen:   w_rdata = '0;
`endif
      AddrWindow: w_rdata = r_window;
      AddrVel:    w_rdata = r_vel;
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      avs_ctrl_readdata <= '0;
    end else if (avs_ctrl_read && !avs_ctrl_write) begin
      avs_ctrl_readdata <= w_rdata;
    end
  end

endmodule
